// File: rtl/priority_encoder_4x2.sv
// rtl/priority_encoder_4x2.sv - registered 4-to-2 priority encoder with valid flag
module priority_encoder_4x2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] D,
  output logic [1:0] Y,
  output logic       Vld
);

  logic [1:0] code;
  logic       any;

  // Highest-numbered asserted bit wins; Y=00 is only meaningful with Vld=1
  always_comb begin
    code = 2'b00;
    any  = 1'b1;
    casez (D)
      4'b1???: code = 2'b11;
      4'b01??: code = 2'b10;
      4'b001?: code = 2'b01;
      4'b0001: code = 2'b00;
      default: begin
        code = 2'b00;
        any  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Y   <= 2'b00;
      Vld <= 1'b0;
    end else if (en) begin
      Y   <= code;
      Vld <= any;
    end
  end

endmodule

// File: tb/tb_priority_encoder_4x2.sv
// tb/tb_priority_encoder_4x2.sv - directed self-checking bench for priority_encoder_4x2
module tb_priority_encoder_4x2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] D;
  logic [1:0] Y;
  logic       Vld;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] sweep_y [16];
  logic       sweep_v [16];

  priority_encoder_4x2 dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .D   (D),
    .Y   (Y),
    .Vld (Vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp_y, input logic exp_v);
    compared++;
    assert (Y === exp_y) else begin
      mismatched++;
      $error("FAIL %s Y: got %b expected %b", tag, Y, exp_y);
    end
    compared++;
    assert (Vld === exp_v) else begin
      mismatched++;
      $error("FAIL %s Vld: got %b expected %b", tag, Vld, exp_v);
    end
  endtask

  initial begin
    sweep_y = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    sweep_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // reset held with en=1 and D=1000
    rst = 1'b1; en = 1'b1; D = 4'b1000;
    tick();
    check("reset_edge1", 2'b00, 1'b0);
    tick();
    check("reset_edge2", 2'b00, 1'b0);
    rst = 1'b0;
    tick();
    check("reset_release", 2'b11, 1'b1);

    // exhaustive sweep
    for (int d = 0; d < 16; d++) begin
      D = 4'(d);
      tick();
      check($sformatf("sweep_d%0d", d), sweep_y[d], sweep_v[d]);
    end

    // priority masking
    D = 4'b0111; tick(); check("mask_0111", 2'b10, 1'b1);
    D = 4'b0011; tick(); check("mask_0011", 2'b01, 1'b1);
    D = 4'b1001; tick(); check("mask_1001", 2'b11, 1'b1);
    D = 4'b0110; tick(); check("mask_0110", 2'b10, 1'b1);

    // hold with en=0
    D = 4'b0100; tick(); check("hold_load", 2'b10, 1'b1);
    en = 1'b0; D = 4'b0000;
    tick(); check("hold_1", 2'b10, 1'b1);
    tick(); check("hold_2", 2'b10, 1'b1);
    D = 4'b1111;
    tick(); check("hold_3", 2'b10, 1'b1);
    D = 4'b0000; en = 1'b1;
    tick(); check("hold_release", 2'b00, 1'b0);

    // reset wins over enable
    D = 4'b1000; tick(); check("rst_pre", 2'b11, 1'b1);
    rst = 1'b1; D = 4'b1111;
    tick(); check("rst_over_en", 2'b00, 1'b0);
    rst = 1'b0; en = 1'b0;
    tick(); check("rst_then_hold", 2'b00, 1'b0);
    en = 1'b1;
    tick(); check("rst_then_load", 2'b11, 1'b1);

    // back-to-back
    D = 4'b0001; tick(); check("b2b_0001", 2'b00, 1'b1);
    D = 4'b1000; tick(); check("b2b_1000", 2'b11, 1'b1);
    D = 4'b0000; tick(); check("b2b_0000", 2'b00, 1'b0);
    D = 4'b0010; tick(); check("b2b_0010", 2'b01, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
